// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one 4x4 multiplier core between two
// requesters, with a watchdog that aborts a multiply whose done never arrives.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | no transaction; arbitrate pending requests, latch owner operands
//  S_GRANT | gnt to owner for one cycle
//  S_START | core_start pulse, watchdog counter cleared
//  S_WAIT  | waiting for core_done; counter runs toward TIMEOUT-1
//  S_DONE  | res_valid to owner; res/res_err held
module mult_share_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       i_sys_clk,
   input  logic       i_sys_rst,
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic [3:0] i_a0,
   input  logic [3:0] i_b0,
   input  logic [3:0] i_a1,
   input  logic [3:0] i_b1,
   input  logic       i_core_done,
   input  logic [7:0] i_core_mp,
   output logic       o_gnt0,
   output logic       o_gnt1,
   output logic       o_res_valid0,
   output logic       o_res_valid1,
   output logic [7:0] o_res,
   output logic       o_res_err,
   output logic       o_core_start,
   output logic [3:0] o_core_a,
   output logic [3:0] o_core_b,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [7:0] TC = 8'(TIMEOUT - 1);

   state_t     r_state;
   logic       r_owner;
   logic       r_last;
   logic [7:0] r_cnt;
   logic [3:0] r_core_a;
   logic [3:0] r_core_b;
   logic [7:0] r_res;
   logic       r_res_err;
   logic       r_gnt0;
   logic       r_gnt1;
   logic       r_res_valid0;
   logic       r_res_valid1;
   logic       r_core_start;
   logic       r_busy;

   logic       w_pick;

   // On a tie the requester that was not served last wins.
   assign w_pick = (i_req0 & i_req1) ? ~r_last : i_req1;

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_last       <= 1'b1;
         r_cnt        <= 8'd0;
         r_core_a     <= 4'd0;
         r_core_b     <= 4'd0;
         r_res        <= 8'd0;
         r_res_err    <= 1'b0;
         r_gnt0       <= 1'b0;
         r_gnt1       <= 1'b0;
         r_res_valid0 <= 1'b0;
         r_res_valid1 <= 1'b0;
         r_core_start <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_gnt0       <= 1'b0;
         r_gnt1       <= 1'b0;
         r_res_valid0 <= 1'b0;
         r_res_valid1 <= 1'b0;
         r_core_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req0 | i_req1) begin
                  r_owner  <= w_pick;
                  r_last   <= w_pick;
                  r_core_a <= w_pick ? i_a1 : i_a0;
                  r_core_b <= w_pick ? i_b1 : i_b0;
                  r_gnt0   <= ~w_pick;
                  r_gnt1   <= w_pick;
                  r_busy   <= 1'b1;
                  r_state  <= S_GRANT;
               end
            end
            S_GRANT: begin
               r_core_start <= 1'b1;
               r_state      <= S_START;
            end
            S_START: begin
               r_cnt   <= 8'd0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // A done arriving on the terminal-count cycle still wins.
               if (i_core_done) begin
                  r_res        <= i_core_mp;
                  r_res_err    <= 1'b0;
                  r_res_valid0 <= ~r_owner;
                  r_res_valid1 <= r_owner;
                  r_state      <= S_DONE;
               end else if (r_cnt == TC) begin
                  r_res        <= 8'h00;
                  r_res_err    <= 1'b1;
                  r_res_valid0 <= ~r_owner;
                  r_res_valid1 <= r_owner;
                  r_state      <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_gnt0       = r_gnt0;
   assign o_gnt1       = r_gnt1;
   assign o_res_valid0 = r_res_valid0;
   assign o_res_valid1 = r_res_valid1;
   assign o_res        = r_res;
   assign o_res_err    = r_res_err;
   assign o_core_start = r_core_start;
   assign o_core_a     = r_core_a;
   assign o_core_b     = r_core_b;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: the stimulus thread predicts owner,
// result and result cycle; an independent monitor checks every result strobe.
module tb_mult_share_arbiter;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic       core_done = 1'b0;
   logic [7:0] core_mp = '0;
   logic       gnt0, gnt1, rv0, rv1, res_err, core_start, busy;
   logic [7:0] res;
   logic [3:0] core_a, core_b;

   mult_share_arbiter #(.TIMEOUT(T)) dut (
      .i_sys_clk   (clk),
      .i_sys_rst   (rst),
      .i_req0      (req0),
      .i_req1      (req1),
      .i_a0        (a0),
      .i_b0        (b0),
      .i_a1        (a1),
      .i_b1        (b1),
      .i_core_done (core_done),
      .i_core_mp   (core_mp),
      .o_gnt0      (gnt0),
      .o_gnt1      (gnt1),
      .o_res_valid0(rv0),
      .o_res_valid1(rv1),
      .o_res       (res),
      .o_res_err   (res_err),
      .o_core_start(core_start),
      .o_core_a    (core_a),
      .o_core_b    (core_b),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         own;
      logic [7:0] res;
      bit         err;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   held0 = 0, held1 = 0;
   bit   last = 1;
   bit   prev_rv = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever a result strobe appears.
   always @(posedge clk) begin
      exp_t e;
      int   n_hot;
      #1;
      if (!rst) begin
         if (prev_rv) chk("busy_after_result", busy, 0);
         n_hot = int'(gnt0) + int'(gnt1) + int'(rv0) + int'(rv1);
         if (n_hot != 0) chk("strobe_onehot", n_hot, 1);
         if (rv0 | rv1) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: rv0=%0b rv1=%0b res=%0h with nothing expected", rv0, rv1, res);
            end else begin
               e = q.pop_front();
               chk("res_owner", rv1, e.own);
               chk("res_value", res, e.res);
               chk("res_err", res_err, e.err);
               chk("res_cycle", cyc, e.cyc);
            end
         end
         prev_rv = rv0 | rv1;
      end else begin
         prev_rv = 0;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) chk("idle_timeout", busy, 0);
   endtask

   // Called in an IDLE cycle. d = WAIT-cycle index of core_done, -1 = never.
   task automatic round(input bit n0, input bit n1,
                        input logic [3:0] na0, input logic [3:0] nb0,
                        input logic [3:0] na1, input logic [3:0] nb1,
                        input int d, input bit ov, input logic [7:0] mv,
                        input bit spur);
      bit         own;
      logic [3:0] ea, eb;
      logic [7:0] mp;
      exp_t       e;
      if (n0 && !held0) begin req0 = 1; a0 = na0; b0 = nb0; held0 = 1; end
      if (n1 && !held1) begin req1 = 1; a1 = na1; b1 = nb1; held1 = 1; end
      if (!held0 && !held1) return;
      own  = (held0 && held1) ? !last : held1;
      last = own;
      if (spur) begin core_done = 1; core_mp = 8'hA5; end
      @(posedge clk); #1;
      chk("gnt0", gnt0, !own);
      chk("gnt1", gnt1, own);
      if (own) begin req1 = 0; held1 = 0; ea = a1; eb = b1; end
      else     begin req0 = 0; held0 = 0; ea = a0; eb = b0; end
      @(posedge clk); #1;
      chk("core_start", core_start, 1);
      chk("core_a", core_a, ea);
      chk("core_b", core_b, eb);
      mp = ov ? mv : ({4'd0, ea} * {4'd0, eb});
      e.own = own;
      if (d >= 0 && d <= T - 1) begin
         e.res = mp; e.err = 0; e.cyc = cyc + 2 + d;
      end else begin
         e.res = 8'h00; e.err = 1; e.cyc = cyc + 1 + T;
      end
      q.push_back(e);
      @(posedge clk); #1;
      core_done = 0;
      if (d >= 0) begin
         repeat (d) begin @(posedge clk); #1; end
         core_done = 1;
         core_mp   = mp;
         @(posedge clk); #1;
         core_done = 0;
         core_mp   = 8'($urandom);
      end
      wait_idle();
   endtask

   task automatic reset_mid_wait();
      req0 = 1; a0 = 4'd6; b0 = 4'd7;
      last = 0;
      @(posedge clk); #1;
      chk("rst_gnt0", gnt0, 1);
      req0 = 0;
      @(posedge clk); #1;
      chk("rst_core_start", core_start, 1);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      last = 1;
      chk("rst_outputs",
          {gnt0, gnt1, rv0, rv1, res, res_err, core_start, core_a, core_b, busy}, 0);
      core_done = 1; core_mp = 8'h2A;
      @(posedge clk); #1;
      core_done = 0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_stays_idle", busy, 0);
      end
   endtask

   initial begin
      bit n0, n1;
      int d;
      rst = 1;
      req0 = 1; a0 = 4'd15; b0 = 4'd15; held0 = 1;
      req1 = 1; a1 = 4'd2;  b1 = 4'd7;  held1 = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {gnt0, gnt1, rv0, rv1, res, res_err, core_start, core_a, core_b, busy}, 0);
      rst = 0;
      round(0, 0, 0, 0, 0, 0, 3, 0, 0, 0);              // tie -> req0, 0xE1
      round(1, 0, 15, 15, 0, 0, 5, 0, 0, 0);            // req1 then, 0x0E
      round(0, 0, 0, 0, 0, 0, 4, 0, 0, 0);              // req0 again
      round(0, 1, 0, 0, 4, 4, -1, 0, 0, 0);             // watchdog abort
      round(1, 0, 7, 9, 0, 0, T - 1, 1, 8'h10, 0);      // done on terminal count
      round(1, 0, 3, 5, 0, 0, 5, 1, 8'h0F, 0);          // done 6 cycles after start
      round(0, 1, 0, 0, 9, 11, 2, 0, 0, 1);             // spurious done in IDLE/GRANT/START
      round(0, 1, 0, 0, 5, 5, T, 0, 0, 0);              // done one cycle too late
      reset_mid_wait();
      round(1, 0, 12, 13, 0, 0, 1, 0, 0, 0);            // normal grant after reset
      for (int i = 0; i < 40; i++) begin
         n0 = 1'($urandom);
         n1 = 1'($urandom);
         if (!n0 && !n1 && !held0 && !held1) n0 = 1;
         d = int'($urandom_range(0, T + 1));
         if (d == T + 1) d = -1;
         round(n0, n1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               d, 1'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0));
      end
      while (held0 || held1) round(0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
      repeat (3) begin @(posedge clk); #1; end
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
